// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, FSM state type and a decode helper.
// Used by the sequential ALU and by the decode stage.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_NOT  = 4'h7;
    localparam logic [3:0] OP_NAND = 4'h8;
    localparam logic [3:0] OP_NOR  = 4'h9;
    localparam logic [3:0] OP_XNOR = 4'hA;
    localparam logic [3:0] OP_SHL1 = 4'hB;
    localparam logic [3:0] OP_SHR1 = 4'hC;
    localparam logic [3:0] OP_ROL1 = 4'hD;
    localparam logic [3:0] OP_ROR1 = 4'hE;
    localparam logic [3:0] OP_MOD  = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    // DIV/MOD share the restoring divider.
    function automatic logic is_divide_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Iterative multiply / unsigned restoring divide, one bit per cycle.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         load operands and begin WIDTH iterations
//   is_div        1: divide a by b, 0: multiply a by b
//   a, b          unsigned operands (magnitudes for signed division)
//   busy          iterations in progress
//   done          final iteration happens at the coming clock edge
//   prod          2*WIDTH-bit product, quot/rem quotient and remainder
// prod/quot/rem show the value after the iteration in progress, so the
// caller can capture the final answer on the same edge that done is high.
module iter_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] prod,
    output logic [WIDTH-1:0]   quot,
    output logic [WIDTH-1:0]   rem
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic               r_busy;
    logic               r_is_div;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_divisor;

    logic [2*WIDTH-1:0] w_acc_next;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_trial;
    logic               w_fits;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quot_next;
    logic               w_last;

    assign w_acc_next  = r_acc + (r_mplier[0] ? r_mcand : '0);

    // Partial remainder < divisor, so the shifted value fits in WIDTH+1 bits
    // and the trial difference's top bit is a clean borrow indicator.
    assign w_shift     = {r_rem, r_quot[WIDTH-1]};
    assign w_trial     = w_shift - {1'b0, r_divisor};
    assign w_fits      = ~w_trial[WIDTH];
    assign w_rem_next  = w_fits ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quot_next = {r_quot[WIDTH-2:0], w_fits};

    assign w_last = r_busy && (r_cnt == CW'(WIDTH - 1));

    assign busy = r_busy;
    assign done = w_last;
    assign prod = w_acc_next;
    assign quot = w_quot_next;
    assign rem  = w_rem_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy    <= 1'b0;
            r_is_div  <= 1'b0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
        end else if (start) begin
            r_busy    <= 1'b1;
            r_is_div  <= is_div;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_mcand   <= {{WIDTH{1'b0}}, a};
            r_mplier  <= b;
            r_quot    <= a;
            r_rem     <= '0;
            r_divisor <= b;
        end else if (r_busy) begin
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                r_busy <= 1'b0;
            end
            if (r_is_div) begin
                r_quot <= w_quot_next;
                r_rem  <= w_rem_next;
            end else begin
                r_acc    <= w_acc_next;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked multi-cycle execute ALU. Simple ops and divide-by-zero finish
// one cycle after acceptance; MUL/DIV/MOD take WIDTH iterations.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        request handshake (ready only when idle)
//   op_a, op_b, ctrl         operands and opcode, latched at acceptance
//   out_valid/out_ready      result handshake
//   result, *_flag           registered result and status flags
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [3:0]       ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic             overflow_flag,
    output logic             divzero_flag
);

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t r_state, w_next;

    logic               w_accept, w_start, w_load, w_b_zero, w_iter_state;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b;
    logic               w_busy, w_done;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot, w_rem;

    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_a, r_b;
    logic               r_neg;

    logic [WIDTH-1:0]   r_result;
    logic               r_zero, r_carry, r_ovf, r_dz;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_res;
    logic               w_carry, w_ovf, w_dz;

    assign w_accept     = (r_state == IDLE) && in_valid;
    assign w_b_zero     = (op_b == '0);
    assign w_start      = w_accept && ((ctrl == OP_MUL) || (is_divide_op(ctrl) && !w_b_zero));
    assign w_iter_state = (r_state == MUL) || (r_state == DIV);
    assign w_load       = (w_accept && !w_start) || (w_iter_state && w_done);

    // Signed DIV runs on magnitudes; MOD and MUL use the raw unsigned values.
    assign w_mag_a = ((ctrl == OP_DIV) && op_a[WIDTH-1]) ? -op_a : op_a;
    assign w_mag_b = ((ctrl == OP_DIV) && op_b[WIDTH-1]) ? -op_b : op_b;

    iter_muldiv #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (w_start),
        .is_div (ctrl != OP_MUL),
        .a      (w_mag_a),
        .b      (w_mag_b),
        .busy   (w_busy),
        .done   (w_done),
        .prod   (w_prod),
        .quot   (w_quot),
        .rem    (w_rem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    if (ctrl == OP_MUL) begin
                        w_next = MUL;
                    end else if (is_divide_op(ctrl) && !w_b_zero) begin
                        w_next = DIV;
                    end else begin
                        w_next = DONE;
                    end
                end
            end
            MUL, DIV: begin
                if (w_done) begin
                    w_next = DONE;
                end else if (!w_busy) begin
                    w_next = IDLE;  // datapath lost its op; recover rather than hang
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // In IDLE this evaluates the incoming request; in MUL/DIV it evaluates
    // the iterative datapath's final answer against the latched operands.
    always_comb begin
        w_sum   = '0;
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        w_dz    = 1'b0;
        if (r_state == IDLE) begin
            case (ctrl)
                OP_ADD: begin
                    w_sum   = {1'b0, op_a} + {1'b0, op_b};
                    w_res   = w_sum[WIDTH-1:0];
                    w_carry = w_sum[WIDTH];
                    w_ovf   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (w_res[WIDTH-1] != op_a[WIDTH-1]);
                end
                OP_SUB: begin
                    w_res   = op_a - op_b;
                    w_carry = (op_a < op_b);
                    w_ovf   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (w_res[WIDTH-1] != op_a[WIDTH-1]);
                end
                OP_DIV: begin
                    w_res = '1;
                    w_dz  = 1'b1;
                end
                OP_MOD:  w_dz = 1'b1;
                OP_AND:  w_res = op_a & op_b;
                OP_OR:   w_res = op_a | op_b;
                OP_XOR:  w_res = op_a ^ op_b;
                OP_NOT:  w_res = ~op_a;
                OP_NAND: w_res = ~(op_a & op_b);
                OP_NOR:  w_res = ~(op_a | op_b);
                OP_XNOR: w_res = ~(op_a ^ op_b);
                OP_SHL1: w_res = {op_a[WIDTH-2:0], 1'b0};
                OP_SHR1: w_res = {1'b0, op_a[WIDTH-1:1]};
                OP_ROL1: w_res = {op_a[WIDTH-2:0], op_a[WIDTH-1]};
                OP_ROR1: w_res = {op_a[0], op_a[WIDTH-1:1]};
                default: w_res = '0;
            endcase
        end else begin
            case (r_op)
                OP_MUL: begin
                    w_res = w_prod[WIDTH-1:0];
                    w_ovf = |w_prod[2*WIDTH-1:WIDTH];
                end
                OP_DIV: begin
                    w_res = r_neg ? -w_quot : w_quot;
                    w_ovf = (r_a == MIN_VAL) && (r_b == '1);
                end
                OP_MOD:  w_res = w_rem;
                default: w_res = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_neg    <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op  <= ctrl;
                r_a   <= op_a;
                r_b   <= op_b;
                r_neg <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
            end
            if (w_load) begin
                r_result <= w_res;
                r_zero   <= (w_res == '0);
                r_carry  <= w_carry;
                r_ovf    <= w_ovf;
                r_dz     <= w_dz;
            end
        end
    end

    assign in_ready      = (r_state == IDLE);
    assign out_valid     = (r_state == DONE);
    assign result        = r_result;
    assign zero_flag     = r_zero;
    assign carry_flag    = r_carry;
    assign overflow_flag = r_ovf;
    assign divzero_flag  = r_dz;

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;
    import alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        iv32, ir32, ov32, rdy32, z32, c32, o32, d32;
    logic [31:0] a32, b32, res32;
    logic [3:0]  op32;
    logic        iv8, ir8, ov8, rdy8, z8, c8, o8, d8;
    logic [7:0]  a8, b8, res8;
    logic [3:0]  op8;

    int errors = 0;
    int checks = 0;

    seq_alu #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
        .op_a(a32), .op_b(b32), .ctrl(op32), .out_valid(ov32), .out_ready(rdy32),
        .result(res32), .zero_flag(z32), .carry_flag(c32),
        .overflow_flag(o32), .divzero_flag(d32)
    );

    seq_alu #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
        .op_a(a8), .op_b(b8), .ctrl(op8), .out_valid(ov8), .out_ready(rdy8),
        .result(res8), .zero_flag(z8), .carry_flag(c8),
        .overflow_flag(o8), .divzero_flag(d8)
    );

    // ---------------- reference model (plain arithmetic) ----------------
    function automatic longint sgn(input longint unsigned x, input int unsigned w);
        if (((x >> (w - 1)) & 64'd1) != 0) return longint'(x) - (longint'(1) << w);
        return longint'(x);
    endfunction

    // Returns {result[31:0], zero, carry, overflow, divzero}.
    function automatic logic [35:0] model(input int unsigned w, input logic [3:0] op,
                                          input logic [31:0] a_in, input logic [31:0] b_in);
        longint unsigned mask = (64'd1 << w) - 64'd1;
        longint unsigned a = 64'(a_in) & mask;
        longint unsigned b = 64'(b_in) & mask;
        longint unsigned r = 0;
        longint sa = sgn(a, w);
        longint sb = sgn(b, w);
        longint smax = (longint'(1) << (w - 1)) - 1;
        longint smin = -(longint'(1) << (w - 1));
        longint s;
        logic c = 1'b0, o = 1'b0, d = 1'b0;
        case (op)
            OP_ADD: begin r = a + b; c = (r >> w) != 0; s = sa + sb; o = (s > smax) || (s < smin); end
            OP_SUB: begin r = a - b; c = a < b; s = sa - sb; o = (s > smax) || (s < smin); end
            OP_MUL: begin r = a * b; o = (r >> w) != 0; end
            OP_DIV: begin
                if (b == 0) begin r = mask; d = 1'b1; end
                else if (sa == smin && sb == -1) begin r = a; o = 1'b1; end
                else r = $unsigned(sa / sb);
            end
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOT:  r = ~a;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XNOR: r = ~(a ^ b);
            OP_SHL1: r = a << 1;
            OP_SHR1: r = a >> 1;
            OP_ROL1: r = (a << 1) | (a >> (w - 1));
            OP_ROR1: r = (a >> 1) | ((a & 64'd1) << (w - 1));
            default: begin
                if (b == 0) begin r = 0; d = 1'b1; end
                else r = a % b;
            end
        endcase
        r = r & mask;
        return {r[31:0], r == 0, c, o, d};
    endfunction

    function automatic int exp_lat(input int unsigned w, input logic [3:0] op, input logic [31:0] b);
        if (op == OP_MUL) return w + 1;
        if ((op == OP_DIV || op == OP_MOD) && b != 0) return w + 1;
        return 1;
    endfunction

    // ---------------- drivers (entered and left #1 after posedge) ----------------
    task automatic issue32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r, output logic [3:0] fl, output int lat);
        op32 = op; a32 = a; b32 = b; iv32 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0; a32 = $urandom; b32 = $urandom; op32 = 4'($urandom);
        lat = 1;
        while (!ov32 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!ov32) begin
            checks++; errors++;
            $display("FAIL timeout32: out_valid=%0b after %0d cycles, required 1", ov32, lat);
        end
        r = res32; fl = {z32, c32, o32, d32};
    endtask

    task automatic issue8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] r, output logic [3:0] fl, output int lat);
        op8 = op; a8 = a; b8 = b; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); op8 = 4'($urandom);
        lat = 1;
        while (!ov8 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!ov8) begin
            checks++; errors++;
            $display("FAIL timeout8: out_valid=%0b after %0d cycles, required 1", ov8, lat);
        end
        r = res8; fl = {z8, c8, o8, d8};
    endtask

    task automatic release32();
        rdy32 = 1'b1; @(posedge clk); #1; rdy32 = 1'b0;
    endtask

    task automatic release8();
        rdy8 = 1'b1; @(posedge clk); #1; rdy8 = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if ({ir32, ov32, res32, z32, c32, o32, d32} !== {1'b1, 1'b0, 32'h0, 4'h0}) begin
            errors++;
            $display("FAIL reset32: ir=%0b ov=%0b res=%h flags=%b, required ir=1 ov=0 res=0 flags=0000",
                     ir32, ov32, res32, {z32, c32, o32, d32});
        end
        checks++;
        if ({ir8, ov8, res8, z8, c8, o8, d8} !== {1'b1, 1'b0, 8'h0, 4'h0}) begin
            errors++;
            $display("FAIL reset8: ir=%0b ov=%0b res=%h flags=%b, required ir=1 ov=0 res=0 flags=0000",
                     ir8, ov8, res8, {z8, c8, o8, d8});
        end
    endtask

    task automatic test_directed();
        logic [3:0]  t_op  [6] = '{OP_ADD, OP_MUL, OP_DIV, OP_DIV, OP_DIV, OP_MOD};
        logic [31:0] t_a   [6] = '{32'hFFFFFFFF, 32'h00010000, 32'hFFFFFFF9, 32'h80000000, 32'd5, 32'd5};
        logic [31:0] t_b   [6] = '{32'h00000001, 32'h00010000, 32'h00000002, 32'hFFFFFFFF, 32'd0, 32'd0};
        logic [31:0] t_r   [6] = '{32'h0, 32'h0, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'h0};
        logic [3:0]  t_fl  [6] = '{4'b1100, 4'b1010, 4'b0000, 4'b0010, 4'b0001, 4'b1001};
        int          t_lat [6] = '{1, 33, 33, 33, 1, 1};
        logic [31:0] r;
        logic [3:0]  fl;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            issue32(t_op[i], t_a[i], t_b[i], r, fl, lat);
            checks++;
            if ({r, fl} !== {t_r[i], t_fl[i]}) begin
                errors++;
                $display("FAIL directed%0d value: res=%h zcod=%b, required res=%h zcod=%b",
                         i, r, fl, t_r[i], t_fl[i]);
            end
            checks++;
            if (lat != t_lat[i]) begin
                errors++;
                $display("FAIL directed%0d latency: %0d, required %0d", i, lat, t_lat[i]);
            end
            release32();
        end
    endtask

    task automatic test_hold();
        logic [31:0] r;
        logic [3:0]  fl;
        int          lat;
        issue32(OP_MOD, 32'd17, 32'd5, r, fl, lat);
        checks++;
        if (r !== 32'd2 || lat != 33) begin
            errors++;
            $display("FAIL hold_first: res=%h lat=%0d, required res=2 lat=33", r, lat);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({ov32, ir32, res32} !== {1'b1, 1'b0, 32'd2}) begin
                errors++;
                $display("FAIL hold_cycle%0d: ov=%0b ir=%0b res=%h, required ov=1 ir=0 res=2",
                         i, ov32, ir32, res32);
            end
        end
        release32();
        checks++;
        if ({ir32, ov32} !== 2'b10) begin
            errors++;
            $display("FAIL hold_release: ir=%0b ov=%0b, required ir=1 ov=0", ir32, ov32);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  simple [13] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_NAND,
                                     OP_NOR, OP_XNOR, OP_SHL1, OP_SHR1, OP_ROL1, OP_ROR1};
        logic [3:0]  cur_op;
        logic [31:0] cur_a, cur_b;
        logic [35:0] exp;
        cur_op = simple[$urandom_range(0, 12)]; cur_a = $urandom; cur_b = $urandom;
        op32 = cur_op; a32 = cur_a; b32 = cur_b; iv32 = 1'b1; rdy32 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            exp = model(32, cur_op, cur_a, cur_b);
            checks++;
            if ({ov32, res32, z32, c32, o32, d32} !== {1'b1, exp}) begin
                errors++;
                $display("FAIL b2b%0d result: ov=%0b res=%h zcod=%b, required ov=1 res=%h zcod=%b",
                         k, ov32, res32, {z32, c32, o32, d32}, exp[35:4], exp[3:0]);
            end
            cur_op = simple[$urandom_range(0, 12)]; cur_a = $urandom; cur_b = $urandom;
            op32 = cur_op; a32 = cur_a; b32 = cur_b;
            @(posedge clk); #1;
            checks++;
            if ({ir32, ov32} !== 2'b10) begin
                errors++;
                $display("FAIL b2b%0d handoff: ir=%0b ov=%0b, required ir=1 ov=0", k, ir32, ov32);
            end
        end
        iv32 = 1'b0; rdy32 = 1'b0;
    endtask

    task automatic test_reset_on_accept();
        op32 = OP_ADD; a32 = 32'd3; b32 = 32'd4; iv32 = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; iv32 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({ir32, ov32, res32} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL rst_accept: ir=%0b ov=%0b res=%h, required ir=1 ov=0 res=0", ir32, ov32, res32);
        end
    endtask

    task automatic test_reset_mid_div32();
        logic [31:0] r;
        logic [3:0]  fl;
        int          lat;
        op32 = OP_DIV; a32 = 32'd1000; b32 = 32'd3; iv32 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if ({ir32, ov32} !== 2'b00) begin
            errors++;
            $display("FAIL mid_div32_busy: ir=%0b ov=%0b, required ir=0 ov=0", ir32, ov32);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({ir32, ov32, res32, z32, c32, o32, d32} !== {1'b1, 1'b0, 32'h0, 4'h0}) begin
            errors++;
            $display("FAIL mid_div32_reset: ir=%0b ov=%0b res=%h flags=%b, required ir=1 ov=0 res=0 flags=0000",
                     ir32, ov32, res32, {z32, c32, o32, d32});
        end
        issue32(OP_ADD, 32'd3, 32'd4, r, fl, lat);
        checks++;
        if ({r, fl} !== {32'd7, 4'b0000} || lat != 1) begin
            errors++;
            $display("FAIL mid_div32_add: res=%h zcod=%b lat=%0d, required res=7 zcod=0000 lat=1", r, fl, lat);
        end
        release32();
    endtask

    task automatic test_reset_mid_div8();
        logic [7:0] r;
        logic [3:0] fl;
        int         lat;
        op8 = OP_DIV; a8 = 8'd100; b8 = 8'd7; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({ir8, ov8, res8, z8, c8, o8, d8} !== {1'b1, 1'b0, 8'h0, 4'h0}) begin
            errors++;
            $display("FAIL mid_div8_reset: ir=%0b ov=%0b res=%h flags=%b, required ir=1 ov=0 res=0 flags=0000",
                     ir8, ov8, res8, {z8, c8, o8, d8});
        end
        issue8(OP_ADD, 8'd3, 8'd4, r, fl, lat);
        checks++;
        if ({r, fl} !== {8'd7, 4'b0000} || lat != 1) begin
            errors++;
            $display("FAIL mid_div8_add: res=%h zcod=%b lat=%0d, required res=7 zcod=0000 lat=1", r, fl, lat);
        end
        release8();
    endtask

    task automatic test_random32();
        logic [3:0]  op;
        logic [31:0] a, b, r;
        logic [3:0]  fl;
        logic [35:0] exp;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15)); a = $urandom; b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: b = 32'($urandom_range(1, 15));
                2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                3: b = a;
                default: ;
            endcase
            exp = model(32, op, a, b);
            issue32(op, a, b, r, fl, lat);
            checks++;
            if ({r, fl} !== exp) begin
                errors++;
                $display("FAIL rand32_%0d op=%h a=%h b=%h: res=%h zcod=%b, required res=%h zcod=%b",
                         i, op, a, b, r, fl, exp[35:4], exp[3:0]);
            end
            checks++;
            if (lat != exp_lat(32, op, b)) begin
                errors++;
                $display("FAIL rand32_%0d latency op=%h: %0d, required %0d", i, op, lat, exp_lat(32, op, b));
            end
            release32();
        end
    endtask

    task automatic test_random8();
        logic [3:0]  op;
        logic [7:0]  a, b, r;
        logic [3:0]  fl;
        logic [35:0] exp;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15)); a = 8'($urandom); b = 8'($urandom);
            case ($urandom_range(0, 7))
                0: b = 8'h0;
                1: b = 8'($urandom_range(1, 5));
                2: begin a = 8'h80; b = 8'hFF; end
                default: ;
            endcase
            exp = model(8, op, {24'h0, a}, {24'h0, b});
            issue8(op, a, b, r, fl, lat);
            checks++;
            if ({24'h0, r, fl} !== exp) begin
                errors++;
                $display("FAIL rand8_%0d op=%h a=%h b=%h: res=%h zcod=%b, required res=%h zcod=%b",
                         i, op, a, b, r, fl, exp[11:4], exp[3:0]);
            end
            checks++;
            if (lat != exp_lat(8, op, {24'h0, b})) begin
                errors++;
                $display("FAIL rand8_%0d latency op=%h: %0d, required %0d", i, op, lat, exp_lat(8, op, {24'h0, b}));
            end
            release8();
        end
    endtask

    initial begin
        rst = 1'b1;
        iv32 = 1'b0; rdy32 = 1'b0; a32 = '0; b32 = '0; op32 = '0;
        iv8  = 1'b0; rdy8  = 1'b0; a8  = '0; b8  = '0; op8  = '0;
        test_reset();
        test_directed();
        test_hold();
        test_back_to_back();
        test_reset_on_accept();
        test_reset_mid_div32();
        test_reset_mid_div8();
        test_random32();
        test_random8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
